// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the chunked sequential adder/subtractor.
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_seq_state_t;

    // Chunk counter needs at least one bit even when a single chunk covers the word.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_seq_chunk_add.sv
// Combinational CHUNK-bit ripple adder built from a chain of full-adder cells.
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    always_comb begin
        logic c;
        c        = cin;
        sum      = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) c_msb_in = c;
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/add_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, LSB chunk first,
// with valid/ready handshakes on both the operand and result sides.
//
// state | meaning
// IDLE  | waiting for an operand packet, in_ready high
// RUN   | adding one chunk per cycle, carry held in a flop
// DONE  | result presented with out_valid, held until out_ready
module add_seq
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);

    add_seq_state_t   state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;

    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout;
    logic             ch_cmsb;

    chunk_add #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_sr[CHUNK-1:0]),
        .b        (b_sr[CHUNK-1:0]),
        .cin      (carry),
        .sum      (ch_sum),
        .cout     (ch_cout),
        .c_msb_in (ch_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a;
                        b_sr     <= sub ? ~b : b;
                        carry    <= sub ? 1'b1 : cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[32'(cnt) * CHUNK +: CHUNK] <= ch_sum;
                    carry <= ch_cout;
                    a_sr  <= a_sr >> CHUNK;
                    b_sr  <= b_sr >> CHUNK;
                    cnt   <= cnt + CW'(1);
                    // The last chunk holds the word MSB, so its carries give cout and ovf.
                    if (cnt == CW'(NCHUNK - 1)) begin
                        cout      <= ch_cout;
                        ovf       <= ch_cmsb ^ ch_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
